mem_access_unit: RTL

- Memory stage that consumes execute-stage load/store requests: mem_read_enable, mem_write_enable, load_sel, store_sel, mem_addr, mem_data and the writeback fields.
- Issues word-aligned, byte-enabled transactions to the data-memory port over a req/gnt/rvalid handshake.
- Sign- or zero-extends load data and produces a one-cycle writeback packet.
- Non-memory ops pass straight through to writeback.

---
 rtl/mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: byte-enabled dmem access, load extension, writeback packet.
// Optional grant/response watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [2:0]  load_sel,
  input  logic [1:0]  store_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [4:0]  reg_write_addr,
  input  logic        reg_write_enable,
  input  logic [31:0] reg_write_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_enable,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    IDLE, REQ, RESP, WB
  } state_t;

  state_t state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [2:0]  lsel_q, lsel_d;
  logic        load_q, load_d;
  logic [4:0]  rd_q, rd_d;
  logic        rwe_q, rwe_d;

  logic        req_ready_d;
  logic        dmem_req_d, dmem_we_d;
  logic [31:0] dmem_addr_d, dmem_wdata_d;
  logic [3:0]  dmem_be_d;
  logic        wb_valid_d, wb_enable_d, fault_d;
  logic [4:0]  wb_addr_d;
  logic [31:0] wb_data_d, fault_addr_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired;
  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Request decode
  logic        ld_half, ld_word, st_half, st_word, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    ld_half = (load_sel == 3'b001) || (load_sel == 3'b100);
    ld_word = !ld_half && (load_sel != 3'b000) && (load_sel != 3'b011);
    st_half = (store_sel == 2'b01);
    st_word = store_sel[1];
    st_be    = 4'b0001 << mem_addr[1:0];
    st_wdata = {4{mem_data[7:0]}};
    if (st_half) begin
      st_be    = 4'b0011 << {mem_addr[1], 1'b0};
      st_wdata = {2{mem_data[15:0]}};
    end
    if (st_word) begin
      st_be    = 4'b1111;
      st_wdata = mem_data;
    end
    if (mem_read_enable)
      misaligned = (ld_half && mem_addr[0]) ||
                   (ld_word && (mem_addr[1:0] != 2'b00));
    else
      misaligned = (st_half && mem_addr[0]) ||
                   (st_word && (mem_addr[1:0] != 2'b00));
  end

  // Load data formatting
  logic [31:0] sh_b, sh_h, ld_data;

  always_comb begin
    sh_b = dmem_rdata >> {addr_q[1:0], 3'b000};
    sh_h = dmem_rdata >> {addr_q[1], 4'b0000};
    unique case (lsel_q)
      3'b000:  ld_data = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  ld_data = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b011:  ld_data = {24'd0, sh_b[7:0]};
      3'b100:  ld_data = {16'd0, sh_h[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lsel_d       = lsel_q;
    load_d       = load_q;
    rd_d         = rd_q;
    rwe_d        = rwe_q;
    dmem_req_d   = dmem_req;
    dmem_we_d    = dmem_we;
    dmem_addr_d  = dmem_addr;
    dmem_be_d    = dmem_be;
    dmem_wdata_d = dmem_wdata;
    wb_valid_d   = 1'b0;
    fault_d      = 1'b0;
    wb_enable_d  = wb_enable;
    wb_addr_d    = wb_addr;
    wb_data_d    = wb_data;
    fault_addr_d = fault_addr;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = mem_addr;
          lsel_d = load_sel;
          load_d = mem_read_enable;
          rd_d   = reg_write_addr;
          rwe_d  = reg_write_enable;
          if (!mem_read_enable && !mem_write_enable) begin
            state_d     = WB;
            wb_valid_d  = 1'b1;
            wb_enable_d = reg_write_enable;
            wb_addr_d   = reg_write_addr;
            wb_data_d   = reg_write_data;
          end else if (misaligned) begin
            state_d      = WB;
            wb_valid_d   = 1'b1;
            wb_enable_d  = 1'b0;
            wb_addr_d    = reg_write_addr;
            fault_d      = 1'b1;
            fault_addr_d = mem_addr;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = !mem_read_enable;
            dmem_addr_d  = {mem_addr[31:2], 2'b00};
            dmem_be_d    = mem_read_enable ? 4'b1111 : st_be;
            dmem_wdata_d = mem_read_enable ? 32'd0 : st_wdata;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (load_q) begin
            state_d = RESP;
          end else begin
            state_d     = WB;
            wb_valid_d  = 1'b1;
            wb_enable_d = 1'b0;
            wb_addr_d   = rd_q;
          end
`ifdef LSU_TIMEOUT_EN
        end else if (expired) begin
          state_d      = WB;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          wb_valid_d   = 1'b1;
          wb_enable_d  = 1'b0;
          wb_addr_d    = rd_q;
          fault_d      = 1'b1;
          fault_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_d     = WB;
          wb_valid_d  = 1'b1;
          wb_enable_d = rwe_q;
          wb_addr_d   = rd_q;
          wb_data_d   = ld_data;
`ifdef LSU_TIMEOUT_EN
        end else if (expired) begin
          state_d      = WB;
          wb_valid_d   = 1'b1;
          wb_enable_d  = 1'b0;
          wb_addr_d    = rd_q;
          fault_d      = 1'b1;
          fault_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lsel_q     <= '0;
      load_q     <= 1'b0;
      rd_q       <= '0;
      rwe_q      <= 1'b0;
      req_ready  <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_enable  <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lsel_q     <= lsel_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      rwe_q      <= rwe_d;
      req_ready  <= req_ready_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_be    <= dmem_be_d;
      dmem_wdata <= dmem_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_enable  <= wb_enable_d;
      wb_addr    <= wb_addr_d;
      wb_data    <= wb_data_d;
      fault      <= fault_d;
      fault_addr <= fault_addr_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule
